// File: rtl/spi_peripheral.sv
// Write-only SPI register slave: synchronises SCLK/COPI/nCS into clk and commits
// validated 16-bit write frames (R/W, 7-bit address, 8-bit data) into five control registers.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] MAX_ADDR_7 = 7'(MAX_ADDR);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_hist;
  logic                   r_ncs_hist;

  state_t      r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_reg0;
  logic [7:0]  r_reg1;
  logic [7:0]  r_reg2;
  logic [7:0]  r_reg3;
  logic [7:0]  r_reg4;

  logic w_sclk_s;
  logic w_copi_s;
  logic w_ncs_s;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_frame_ok;

  // The history flops sit after the last synchroniser stage so edges are seen on clean levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_hist <= 1'b0;
      r_ncs_hist  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_hist <= w_sclk_s;
      r_ncs_hist  <= w_ncs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;

  assign w_frame_ok = (r_bit_cnt == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_ADDR_7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_reg0    <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_reg3    <= '0;
      r_reg4    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ncs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // nCS rise wins over a coincident SCLK rise; the counter saturates at 16.
          if (w_ncs_rise) begin
            r_state <= S_COMMIT;
          end else if (w_sclk_rise && (r_bit_cnt != 5'd16)) begin
            r_shift   <= {r_shift[14:0], w_copi_s};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        S_COMMIT: begin
          if (w_frame_ok) begin
            case (r_shift[14:8])
              7'd0:    r_reg0 <= r_shift[7:0];
              7'd1:    r_reg1 <= r_shift[7:0];
              7'd2:    r_reg2 <= r_shift[7:0];
              7'd3:    r_reg3 <= r_shift[7:0];
              7'd4:    r_reg4 <= r_shift[7:0];
              default: ;
            endcase
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a frame table with hand-computed register images,
// plus hand sequences for reset, idle stability and mid-frame reset.
module tb_spi_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Register image packed as {duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}.
  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic [39:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [39:0] exp_q[$];
  logic [39:0] prev_exp;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkers
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [39:0] e);
    check8({tag, " out_7_0"},  en_reg_out_7_0,  e[7:0]);
    check8({tag, " out_15_8"}, en_reg_out_15_8, e[15:8]);
    check8({tag, " pwm_7_0"},  en_reg_pwm_7_0,  e[23:16]);
    check8({tag, " pwm_15_8"}, en_reg_pwm_15_8, e[31:24]);
    check8({tag, " duty"},     pwm_duty_cycle,  e[39:32]);
  endtask

  // Drivers: all pins change on the falling clk edge; each SCLK phase lasts 4 clk periods.
  task automatic cs_low();
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15 - i] : 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Raises nCS, checks the registers are still old after edge 3 and new after edge 4.
  task automatic cs_high_and_check(input string tag, input logic [39:0] old_e,
                                   input logic [39:0] new_e);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    check_regs({tag, " pre"}, old_e);
    @(negedge clk);
    check_regs({tag, " post"}, new_e);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{16'h80F0, 16, 40'h00_00_00_00_F0};
    vecs[1] = '{16'h8480, 16, 40'h80_00_00_00_F0};
    vecs[2] = '{16'h04FF, 16, 40'h80_00_00_00_F0};
    vecs[3] = '{16'h85AA, 16, 40'h80_00_00_00_F0};
    vecs[4] = '{16'hFFAA, 16, 40'h80_00_00_00_F0};
    vecs[5] = '{16'h8155, 15, 40'h80_00_00_00_F0};
    vecs[6] = '{16'h8155, 16, 40'h80_00_00_55_F0};
    vecs[7] = '{16'h8233, 17, 40'h80_00_33_55_F0};
    vecs[8] = '{16'h800F, 16, 40'h80_00_33_55_0F};
    vecs[9] = '{16'h8311, 16, 40'h80_11_33_55_0F};

    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(negedge clk);
    check_regs("reset", 40'h0);
    check8("reset state", {6'd0, dbg_state}, 8'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_regs("idle 100", 40'h0);
    check8("idle state", {6'd0, dbg_state}, 8'd0);

    prev_exp = 40'h0;
    foreach (vecs[k]) exp_q.push_back(vecs[k].exp);
    for (int k = 0; k < 10; k++) begin
      logic [39:0] e;
      e = exp_q.pop_front();
      cs_low();
      shift_bits(vecs[k].frame, vecs[k].nbits);
      cs_high_and_check($sformatf("vec%0d", k), prev_exp, e);
      prev_exp = e;
    end

    // Reset in the middle of a frame drops everything, then a clean frame lands.
    cs_low();
    shift_bits(16'h83CC, 8);
    rst_n = 1'b0;
    #1;
    check_regs("midframe reset", 40'h0);
    check8("midframe reset state", {6'd0, dbg_state}, 8'd0);
    ncs  = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cs_low();
    shift_bits(16'h83CC, 16);
    cs_high_and_check("after reset", 40'h0, 40'h00_CC_00_00_00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
